// File: rtl/sort4_seq_ctrl.sv
// sort4_seq_ctrl: multi-cycle four-field sorter reusing one compare-swap unit over a 6-step bubble schedule
// Ports: clk, rst (sync, active-high); start/data_in request a sort; busy is high while sorting;
//        done pulses for one cycle when sorted/swap_cnt are loaded; results hold until the next completion.
module sort4_seq_ctrl #(
  parameter int W = 2,
  parameter int ORDER = 0,
  parameter int EARLY_EXIT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [4*W-1:0] data_in,
  output logic           busy,
  output logic           done,
  output logic [4*W-1:0] sorted,
  output logic [2:0]     swap_cnt
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
  logic [1:0] state, idx;
  logic [2:0] step, cnt, ncnt;
  logic pass_sw, nps, swp, last;
  logic [W-1:0] r [4];
  logic [W-1:0] nr [4];
  logic [W-1:0] a, b;
  assign busy = state == RUN;
  assign done = state == FIN;
  // step -> left index of the compared pair: 0,1,2 | 0,1 | 0
  always_comb begin
    idx = (step == 3'd1 || step == 3'd4) ? 2'd1 : (step == 3'd2) ? 2'd2 : 2'd0;
    a = r[idx];
    b = r[idx + 2'd1];
    swp = (ORDER != 0) ? a > b : a < b;
    nr = r;
    nr[idx] = swp ? b : a;
    nr[idx + 2'd1] = swp ? a : b;
    ncnt = cnt + {2'b0, swp};
    nps = pass_sw | swp;
    // steps 2 and 4 close a bubble pass; a swap-free pass means the data is already in order
    last = step == 3'd5 || (EARLY_EXIT != 0 && (step == 3'd2 || step == 3'd4) && !nps);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step <= '0;
      cnt <= '0;
      pass_sw <= 1'b0;
      r <= '{default: '0};
      sorted <= '0;
      swap_cnt <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= RUN;
        step <= '0;
        cnt <= '0;
        pass_sw <= 1'b0;
        for (int i = 0; i < 4; i++) r[i] <= data_in[(3-i)*W +: W];
      end
    end else if (state == RUN) begin
      r <= nr;
      cnt <= ncnt;
      step <= step + 3'd1;
      pass_sw <= (step == 3'd2 || step == 3'd4) ? 1'b0 : nps;
      if (last) begin
        state <= FIN;
        sorted <= {nr[0], nr[1], nr[2], nr[3]};
        swap_cnt <= ncnt;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// tb_sort4_seq_ctrl: random and exhaustive checks of three sorter configurations against a reference model
module tb_sort4_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] busy, done;
  logic [7:0] srt [3];
  logic [2:0] sc [3];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // d0: descending, full schedule; d1: ascending, full schedule; d2: descending, early exit
  sort4_seq_ctrl #(.W(2), .ORDER(0), .EARLY_EXIT(0)) d0 (.clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy[0]), .done(done[0]), .sorted(srt[0]), .swap_cnt(sc[0]));
  sort4_seq_ctrl #(.W(2), .ORDER(1), .EARLY_EXIT(0)) d1 (.clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy[1]), .done(done[1]), .sorted(srt[1]), .swap_cnt(sc[1]));
  sort4_seq_ctrl #(.W(2), .ORDER(0), .EARLY_EXIT(1)) d2 (.clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy[2]), .done(done[2]), .sorted(srt[2]), .swap_cnt(sc[2]));

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit ooo(input int x, input int y, input bit ord);
    return ord ? x > y : x < y;
  endfunction

  // Sorted result by counting values, swap count as the inversion count, latency from per-pass swap activity
  function automatic void model(input logic [7:0] d, input bit ord, input bit ee,
                                output int s, output int swaps, output int lat);
    int f [4];
    int ps [3];
    int t;
    for (int i = 0; i < 4; i++) f[i] = int'(d[7-2*i -: 2]);
    s = 0;
    for (int n = 0; n < 4; n++) begin
      int v = ord ? n : 3 - n;
      for (int i = 0; i < 4; i++) if (f[i] == v) s = (s << 2) | v;
    end
    swaps = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++) if (ooo(f[i], f[j], ord)) swaps++;
    for (int p = 0; p < 3; p++) begin
      ps[p] = 0;
      for (int j = 0; j < 3 - p; j++)
        if (ooo(f[j], f[j+1], ord)) begin
          t = f[j]; f[j] = f[j+1]; f[j+1] = t; ps[p]++;
        end
    end
    lat = !ee ? 6 : ps[0] == 0 ? 3 : ps[1] == 0 ? 5 : 6;
  endfunction

  // One sort: optionally holds start high with data 8'hFF while running (and into FIN of the fastest unit)
  task automatic run(input logic [7:0] d, input bit garbage);
    int lat [3];
    int nd [3];
    int nb [3];
    int es, esw, el;
    for (int k = 0; k < 3; k++) begin lat[k] = -1; nd[k] = 0; nb[k] = 0; end
    @(negedge clk);
    start = 1'b1;
    data_in = d;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (done[k]) begin nd[k]++; if (lat[k] < 0) lat[k] = c - 1; end
        if (busy[k]) nb[k]++;
      end
      start = garbage && c <= 4;
      data_in = garbage ? 8'hFF : d;
    end
    for (int k = 0; k < 3; k++) begin
      model(d, k == 1, k == 2, es, esw, el);
      chk($sformatf("sorted[%0d] d=%h", k, d), int'(srt[k]), es);
      chk($sformatf("swap_cnt[%0d] d=%h", k, d), int'(sc[k]), esw);
      chk($sformatf("latency[%0d] d=%h", k, d), lat[k], el);
      chk($sformatf("done_pulses[%0d] d=%h", k, d), nd[k], 1);
      chk($sformatf("busy_cycles[%0d] d=%h", k, d), nb[k], el);
    end
  endtask

  initial begin
    int nd;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", int'(busy[k]), 0);
      chk("rst_done", int'(done[k]), 0);
      chk("rst_sorted", int'(srt[k]), 0);
      chk("rst_swap_cnt", int'(sc[k]), 0);
    end
    rst = 1'b0;
    run(8'h1B, 1'b0);
    run(8'hE4, 1'b0);
    run(8'h55, 1'b0);
    run(8'h4D, 1'b0);
    run(8'h1B, 1'b1);
    for (int n = 0; n < 40; n++) run(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    for (int d = 0; d < 256; d++) run(8'(d), 1'($urandom_range(0, 1)));
    // Abort a sort with reset while step 3 is pending
    @(negedge clk);
    start = 1'b1;
    data_in = 8'h1B;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("abort_busy", int'(busy[k]), 0);
      chk("abort_done", int'(done[k]), 0);
      chk("abort_sorted", int'(srt[k]), 0);
      chk("abort_swap_cnt", int'(sc[k]), 0);
    end
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      nd += int'(done[0]) + int'(done[1]) + int'(done[2]);
    end
    chk("abort_no_done", nd, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
